datapath: RTL and testbench
===========================

Name: datapath

Overview:
- Single-bus 32-bit CPU datapath slice: general registers R2/R4/R5, PC, IR, MAR, MDR, ALU operand latch Y, and result register Z (64-bit; only Zlow is drivable onto the bus).
- Driven cycle-by-cycle by a control unit (or bench FSM) through one-hot register out/in strobes, ALU op strobes and memory Read.
- Memory data enters via Mdatain into MDR. Register contents are exported for observation.

Parameters:
- DATA_W, 32, width of the bus, registers, Mdatain and ALU.

Ports:
- Clock  in  1  system clock; all registers update on rising edge.
- Reset  in  1  synchronous, active-high reset.
- PCout, Zlowout, MDRout, R2out, R4out  in  1 each  bus source strobes.
- MARin, Zin, PCin, MDRin, IRin, Yin, R2in, R4in, R5in  in  1 each  register load enables.
- IncPC  in  1  ALU op: bus + 1.
- AND  in  1  ALU op: Y & bus.
- Read  in  1  MDR input select: 1 = Mdatain, 0 = bus.
- Mdatain  in  DATA_W  memory read data.
- BusMuxOut  out  DATA_W  current bus value (combinational).
- R2_q, R4_q, R5_q, PC_q, IR_q, MAR_q, MDR_q, Y_q, Zlow_q  out  DATA_W each  register contents.

Behaviour:
- Reset: every register (R2, R4, R5, PC, IR, MAR, MDR, Y, Z all 64 bits) is cleared to 0 on the rising edge when Reset=1. Reset overrides all load enables. All q outputs therefore read 0 after a reset edge.
- Bus mux (combinational), fixed priority when several out strobes are high: MDRout > Zlowout > R2out > R4out > PCout.
  - No out strobe high -> BusMuxOut = 0.
- Register loads: on rising edge with Reset=0, each register whose *in strobe is high captures BusMuxOut. This covers R2, R4, R5, PC, IR, MAR and Y.
- MDR load: on MDRin=1, MDR captures Mdatain if Read=1, else BusMuxOut.
- ALU (combinational), result C[2*DATA_W-1:0]:
  - AND=1 -> C = {0, Y & BusMuxOut}.
  - else IncPC=1 -> C = {0, BusMuxOut + 1}; addition wraps mod 2^DATA_W, no carry kept.
  - else -> C = {0, BusMuxOut}.
  - AND has priority over IncPC.
- Z: on Zin=1, Z captures C. Zlow = Z[DATA_W-1:0]. Zhigh is stored but never driven onto the bus.
- Single-cycle timing: a register loaded on edge N is visible on the bus and on its q output after edge N, so a value moves source -> destination in one cycle.
  - A register both driving and loading in the same cycle captures its own old value.
- Simultaneous loads: any number of *in strobes may be high at once; all selected registers capture the same bus value.
- Reset asserted mid-sequence clears all state on that edge. Sequencing resumes from the zeroed state.
- No internal state machine; all control is external.

Optional Feature:
- Macro BUS_CONFLICT_CHECK_EN.
- Defined: adds output port BusConflict (1 bit, combinational), high whenever two or more of PCout/Zlowout/MDRout/R2out/R4out are high in the same cycle. Bus selection still follows the fixed priority.
- Undefined: port absent; behaviour otherwise identical.

Test Plan:
- Reset: load nonzero values, then hold Reset=1 for one edge -> all q outputs = 0; BusMuxOut = 0 with no out strobe.
- Register init: Mdatain=0x22, Read=1, MDRin=1 for one edge -> MDR_q=0x22. Next edge with MDRout=1, R2in=1 -> R2_q=0x22. Repeat with 0x24 -> R4 and 0x26 -> R5.
- Fetch: PC=0; PCout, MARin, IncPC, Zin for one edge -> MAR_q=0, Zlow_q=1. Next edge with Zlowout, PCin, Read, MDRin, Mdatain=0x4A920000 -> PC_q=1, MDR_q=0x4A920000. Next edge with MDRout, IRin -> IR_q=0x4A920000.
- AND: R2=0x22, R4=0x24. R2out+Yin -> Y_q=0x22. Then R4out+AND+Zin -> Zlow_q=0x20. Then Zlowout+R5in -> R5_q=0x20.
- Boundaries:
  - PC=0xFFFFFFFF, PCout+IncPC+Zin -> Zlow_q=0, Z high half=0.
  - MDRout and R2out high together -> BusMuxOut=MDR; BusConflict=1 when the macro is enabled.
  - Read=0 with MDRin -> MDR captures the bus.

Source files
------------

// File: rtl/datapath.sv
// Single-bus 32-bit datapath slice: R2/R4/R5, PC, IR, MAR, MDR, Y and a 64-bit Z.
// Optional BusConflict output is enabled by defining BUS_CONFLICT_CHECK_EN.
module datapath #(
  parameter int DATA_W = 32
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              PCout,
  input  logic              Zlowout,
  input  logic              MDRout,
  input  logic              R2out,
  input  logic              R4out,
  input  logic              MARin,
  input  logic              Zin,
  input  logic              PCin,
  input  logic              MDRin,
  input  logic              IRin,
  input  logic              Yin,
  input  logic              R2in,
  input  logic              R4in,
  input  logic              R5in,
  input  logic              IncPC,
  input  logic              AND,
  input  logic              Read,
  input  logic [DATA_W-1:0] Mdatain,
  output logic [DATA_W-1:0] BusMuxOut,
  output logic [DATA_W-1:0] R2_q,
  output logic [DATA_W-1:0] R4_q,
  output logic [DATA_W-1:0] R5_q,
  output logic [DATA_W-1:0] PC_q,
  output logic [DATA_W-1:0] IR_q,
  output logic [DATA_W-1:0] MAR_q,
  output logic [DATA_W-1:0] MDR_q,
  output logic [DATA_W-1:0] Y_q,
  output logic [DATA_W-1:0] Zlow_q
`ifdef BUS_CONFLICT_CHECK_EN
  ,
  output logic              BusConflict
`endif
);

  localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

  logic [2*DATA_W-1:0] alu_c;
  logic [2*DATA_W-1:0] z_q;
  logic                unused_zhigh;

  always_comb begin
    BusMuxOut = '0;
    if (MDRout)       BusMuxOut = MDR_q;
    else if (Zlowout) BusMuxOut = z_q[DATA_W-1:0];
    else if (R2out)   BusMuxOut = R2_q;
    else if (R4out)   BusMuxOut = R4_q;
    else if (PCout)   BusMuxOut = PC_q;
  end

`ifdef BUS_CONFLICT_CHECK_EN
  logic [4:0] src_sel;
  assign src_sel     = {PCout, Zlowout, MDRout, R2out, R4out};
  // More than one bit set iff clearing the lowest set bit leaves something.
  assign BusConflict = (src_sel & (src_sel - 5'd1)) != 5'd0;
`endif

  always_comb begin
    alu_c = {{DATA_W{1'b0}}, BusMuxOut};
    if (AND)        alu_c = {{DATA_W{1'b0}}, Y_q & BusMuxOut};
    else if (IncPC) alu_c = {{DATA_W{1'b0}}, BusMuxOut + ONE};
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      R2_q  <= '0;
      R4_q  <= '0;
      R5_q  <= '0;
      PC_q  <= '0;
      IR_q  <= '0;
      MAR_q <= '0;
      MDR_q <= '0;
      Y_q   <= '0;
      z_q   <= '0;
    end else begin
      if (R2in)  R2_q  <= BusMuxOut;
      if (R4in)  R4_q  <= BusMuxOut;
      if (R5in)  R5_q  <= BusMuxOut;
      if (PCin)  PC_q  <= BusMuxOut;
      if (IRin)  IR_q  <= BusMuxOut;
      if (MARin) MAR_q <= BusMuxOut;
      if (Yin)   Y_q   <= BusMuxOut;
      if (MDRin) MDR_q <= Read ? Mdatain : BusMuxOut;
      if (Zin)   z_q   <= alu_c;
    end
  end

  // Zhigh is kept in the register but has no bus path.
  assign Zlow_q       = z_q[DATA_W-1:0];
  assign unused_zhigh = ^z_q[2*DATA_W-1:DATA_W];

endmodule

// File: tb/tb_datapath.sv
// Directed self-checking bench for datapath; BUS_CONFLICT_CHECK_EN adds conflict checks.
module tb_datapath;
  localparam int DATA_W = 32;

  logic Clock, Reset;
  logic PCout, Zlowout, MDRout, R2out, R4out;
  logic MARin, Zin, PCin, MDRin, IRin, Yin, R2in, R4in, R5in;
  logic IncPC, AND, Read;
  logic [DATA_W-1:0] Mdatain;
  logic [DATA_W-1:0] BusMuxOut, R2_q, R4_q, R5_q, PC_q, IR_q, MAR_q, MDR_q, Y_q, Zlow_q;
`ifdef BUS_CONFLICT_CHECK_EN
  logic BusConflict;
`endif

  int passed = 0;
  int total  = 0;

  datapath #(.DATA_W(DATA_W)) dut (
    .Clock(Clock), .Reset(Reset),
    .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .R2out(R2out), .R4out(R4out),
    .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .R2in(R2in), .R4in(R4in), .R5in(R5in),
    .IncPC(IncPC), .AND(AND), .Read(Read), .Mdatain(Mdatain),
    .BusMuxOut(BusMuxOut), .R2_q(R2_q), .R4_q(R4_q), .R5_q(R5_q), .PC_q(PC_q),
    .IR_q(IR_q), .MAR_q(MAR_q), .MDR_q(MDR_q), .Y_q(Y_q), .Zlow_q(Zlow_q)
`ifdef BUS_CONFLICT_CHECK_EN
    , .BusConflict(BusConflict)
`endif
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic clear_ctl();
    Reset = 0; PCout = 0; Zlowout = 0; MDRout = 0; R2out = 0; R4out = 0;
    MARin = 0; Zin = 0; PCin = 0; MDRin = 0; IRin = 0; Yin = 0;
    R2in = 0; R4in = 0; R5in = 0; IncPC = 0; AND = 0; Read = 0; Mdatain = '0;
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
    clear_ctl();
  endtask

  task automatic test_reset();
    clear_ctl(); Reset = 1; tick();
    Mdatain = 32'h55; Read = 1; MDRin = 1; tick();
    MDRout = 1; R2in = 1; R4in = 1; R5in = 1; PCin = 1; IRin = 1; MARin = 1; Yin = 1; Zin = 1;
    tick();
    total++; if (R2_q !== 32'h55) $display("FAIL preload_r2 got %h exp %h", R2_q, 32'h55); else passed++;
    total++; if (Zlow_q !== 32'h55) $display("FAIL preload_z got %h exp %h", Zlow_q, 32'h55); else passed++;
    Reset = 1; MDRout = 1; R2in = 1; PCin = 1; Zin = 1; MDRin = 1; Read = 1; Mdatain = 32'h77;
    tick();
    total++;
    if ({R2_q, R4_q, R5_q, PC_q, IR_q, MAR_q, MDR_q, Y_q, Zlow_q} !== '0)
      $display("FAIL reset_regs got r2=%h r4=%h r5=%h pc=%h ir=%h mar=%h mdr=%h y=%h z=%h exp all 0",
               R2_q, R4_q, R5_q, PC_q, IR_q, MAR_q, MDR_q, Y_q, Zlow_q);
    else passed++;
    total++; if (BusMuxOut !== '0) $display("FAIL reset_bus got %h exp 0", BusMuxOut); else passed++;
  endtask

  task automatic test_register_init();
    Mdatain = 32'h22; Read = 1; MDRin = 1; tick();
    total++; if (MDR_q !== 32'h22) $display("FAIL init_mdr got %h exp %h", MDR_q, 32'h22); else passed++;
    MDRout = 1; R2in = 1; tick();
    total++; if (R2_q !== 32'h22) $display("FAIL init_r2 got %h exp %h", R2_q, 32'h22); else passed++;
    Mdatain = 32'h24; Read = 1; MDRin = 1; tick();
    MDRout = 1; R4in = 1; tick();
    total++; if (R4_q !== 32'h24) $display("FAIL init_r4 got %h exp %h", R4_q, 32'h24); else passed++;
    Mdatain = 32'h26; Read = 1; MDRin = 1; tick();
    MDRout = 1; R5in = 1; tick();
    total++; if (R5_q !== 32'h26) $display("FAIL init_r5 got %h exp %h", R5_q, 32'h26); else passed++;
  endtask

  task automatic test_fetch();
    PCout = 1; MARin = 1; IncPC = 1; Zin = 1; tick();
    total++; if (MAR_q !== 32'h0) $display("FAIL fetch_mar got %h exp 0", MAR_q); else passed++;
    total++; if (Zlow_q !== 32'h1) $display("FAIL fetch_z got %h exp 1", Zlow_q); else passed++;
    Zlowout = 1; PCin = 1; Read = 1; MDRin = 1; Mdatain = 32'h4A920000; tick();
    total++; if (PC_q !== 32'h1) $display("FAIL fetch_pc got %h exp 1", PC_q); else passed++;
    total++; if (MDR_q !== 32'h4A920000) $display("FAIL fetch_mdr got %h exp 4a920000", MDR_q); else passed++;
    MDRout = 1; IRin = 1; tick();
    total++; if (IR_q !== 32'h4A920000) $display("FAIL fetch_ir got %h exp 4a920000", IR_q); else passed++;
  endtask

  task automatic test_and();
    R2out = 1; Yin = 1; tick();
    total++; if (Y_q !== 32'h22) $display("FAIL and_y got %h exp 22", Y_q); else passed++;
    // IncPC also high: AND must win (0x20, not 0x25)
    R4out = 1; AND = 1; IncPC = 1; Zin = 1; tick();
    total++; if (Zlow_q !== 32'h20) $display("FAIL and_z got %h exp 20", Zlow_q); else passed++;
    Zlowout = 1; R5in = 1; tick();
    total++; if (R5_q !== 32'h20) $display("FAIL and_r5 got %h exp 20", R5_q); else passed++;
  endtask

  task automatic test_inc_wrap();
    Mdatain = 32'hFFFFFFFF; Read = 1; MDRin = 1; tick();
    MDRout = 1; PCin = 1; tick();
    total++; if (PC_q !== 32'hFFFFFFFF) $display("FAIL wrap_pc got %h exp ffffffff", PC_q); else passed++;
    PCout = 1; IncPC = 1; Zin = 1; tick();
    total++; if (Zlow_q !== 32'h0) $display("FAIL wrap_z got %h exp 0", Zlow_q); else passed++;
  endtask

  task automatic test_bus_priority();
    // MDR=ffffffff, Zlow=0, R2=22, R4=24, PC=ffffffff
    MDRout = 1; R2out = 1; Zlowout = 1; #1;
    total++; if (BusMuxOut !== 32'hFFFFFFFF) $display("FAIL prio_mdr got %h exp ffffffff", BusMuxOut); else passed++;
`ifdef BUS_CONFLICT_CHECK_EN
    total++; if (BusConflict !== 1'b1) $display("FAIL conflict_hi got %b exp 1", BusConflict); else passed++;
`endif
    clear_ctl(); R2out = 1; R4out = 1; PCout = 1; #1;
    total++; if (BusMuxOut !== 32'h22) $display("FAIL prio_r2 got %h exp 22", BusMuxOut); else passed++;
    clear_ctl(); R4out = 1; PCout = 1; #1;
    total++; if (BusMuxOut !== 32'h24) $display("FAIL prio_r4 got %h exp 24", BusMuxOut); else passed++;
    clear_ctl(); Zlowout = 1; R4out = 1; #1;
    total++; if (BusMuxOut !== 32'h0) $display("FAIL prio_zlow got %h exp 0", BusMuxOut); else passed++;
    clear_ctl(); R4out = 1; #1;
`ifdef BUS_CONFLICT_CHECK_EN
    total++; if (BusConflict !== 1'b0) $display("FAIL conflict_lo got %b exp 0", BusConflict); else passed++;
`endif
    clear_ctl();
  endtask

  task automatic test_mdr_bus_load();
    R4out = 1; MDRin = 1; Read = 0; Mdatain = 32'hDEAD; tick();
    total++; if (MDR_q !== 32'h24) $display("FAIL mdr_bus got %h exp 24", MDR_q); else passed++;
  endtask

  task automatic test_back_to_back();
    R2out = 1; R5in = 1; MARin = 1; Yin = 1; tick();
    total++; if ({R5_q, MAR_q, Y_q} !== {3{32'h22}})
      $display("FAIL multi_load got r5=%h mar=%h y=%h exp 22", R5_q, MAR_q, Y_q); else passed++;
    R4out = 1; R4in = 1; R2in = 1; tick();
    total++; if ({R4_q, R2_q} !== {2{32'h24}})
      $display("FAIL self_load got r4=%h r2=%h exp 24", R4_q, R2_q); else passed++;
  endtask

  task automatic test_reset_midsequence();
    Reset = 1; R2out = 1; PCin = 1; tick();
    total++; if ({PC_q, R2_q, MDR_q} !== '0)
      $display("FAIL mid_reset got pc=%h r2=%h mdr=%h exp 0", PC_q, R2_q, MDR_q); else passed++;
    PCout = 1; IncPC = 1; Zin = 1; tick();
    total++; if (Zlow_q !== 32'h1) $display("FAIL resume_z got %h exp 1", Zlow_q); else passed++;
  endtask

  initial begin
    clear_ctl();
    test_reset();
    test_register_init();
    test_fetch();
    test_and();
    test_inc_wrap();
    test_bus_priority();
    test_mdr_bus_load();
    test_back_to_back();
    test_reset_midsequence();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
